// File: rtl/nvme_pcie_pkg.sv
// Shared types and constants for the NVMe PCIe doorbell path.
package nvme_pcie_pkg;

    localparam int ADDR_W    = 64;
    localparam int DBL_VAL_W = 16;

    localparam logic [3:0] REQ_TYPE_MEMWR = 4'b0001;

    typedef enum logic [1:0] {
        DBL_IDLE,
        DBL_DESC,
        DBL_DATA
    } dbl_state_e;

    // RQ descriptor for a 1-DW posted memory write; address bits [1:0] are implied zero.
    function automatic logic [127:0] memwr_desc(input logic [ADDR_W-1:2] addr,
                                                input logic [7:0]        tag);
        logic [127:0] d;
        d          = '0;
        d[63:2]    = addr;
        d[74:64]   = 11'd1;
        d[78:75]   = REQ_TYPE_MEMWR;
        d[103:96]  = tag;
        return d;
    endfunction

endpackage

// File: rtl/doorbell_writer.sv
// Serialises SQ-tail / CQ-head doorbell updates into 1-DW MemWr TLPs on the RQ interface.
module doorbell_writer
    import nvme_pcie_pkg::*;
#(
    parameter int C_DATA_WIDTH        = 128,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32
) (
    input  logic                           user_clk,
    input  logic                           user_reset_n,
    input  logic                           write_sqtdbl,
    input  logic [ADDR_W-1:0]              sqt_addr,
    input  logic [DBL_VAL_W-1:0]           sqt_val,
    input  logic                           write_cqhdbl,
    input  logic [ADDR_W-1:0]              cqh_addr,
    input  logic [DBL_VAL_W-1:0]           cqh_val,
    output logic                           write_sqtdbl_done,
    output logic                           write_cqhdbl_done,
    output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
    output logic                           s_axis_rq_tlast,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
    output logic                           s_axis_rq_tvalid,
    input  logic                           s_axis_rq_tready,
    output logic                           dbl_busy
);

    dbl_state_e                     state_q, state_d;
    logic                           sq_pend_q, sq_pend_d;
    logic                           cq_pend_q, cq_pend_d;
    logic [ADDR_W-1:0]              sq_addr_q, sq_addr_d;
    logic [ADDR_W-1:0]              cq_addr_q, cq_addr_d;
    logic [DBL_VAL_W-1:0]           sq_val_q, sq_val_d;
    logic [DBL_VAL_W-1:0]           cq_val_q, cq_val_d;
    logic [DBL_VAL_W-1:0]           dval_q, dval_d;
    logic                           serve_cq_q, serve_cq_d;
    logic [7:0]                     tag_q, tag_d;
    logic                           sq_done_q, sq_done_d;
    logic                           cq_done_q, cq_done_d;
    logic [C_DATA_WIDTH-1:0]        tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]          tkeep_q, tkeep_d;
    logic                           tlast_q, tlast_d;
    logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic                           start_sq, start_cq;
    logic                           unused_addr_lsbs;

    assign unused_addr_lsbs = ^{sq_addr_q[1:0], cq_addr_q[1:0]};

    always_comb begin
        state_d    = state_q;
        sq_pend_d  = sq_pend_q;
        cq_pend_d  = cq_pend_q;
        sq_addr_d  = sq_addr_q;
        cq_addr_d  = cq_addr_q;
        sq_val_d   = sq_val_q;
        cq_val_d   = cq_val_q;
        dval_d     = dval_q;
        serve_cq_d = serve_cq_q;
        tag_d      = tag_q;
        sq_done_d  = 1'b0;
        cq_done_d  = 1'b0;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        start_sq   = 1'b0;
        start_cq   = 1'b0;

        unique case (state_q)
            DBL_IDLE: begin
                if (sq_pend_q || cq_pend_q) begin
                    start_sq   = sq_pend_q;
                    start_cq   = !sq_pend_q;
                    serve_cq_d = !sq_pend_q;
                    state_d    = DBL_DESC;
                    // Beat payload is snapshotted here so later requests cannot disturb it.
                    tdata_d    = C_DATA_WIDTH'(memwr_desc(sq_pend_q ? sq_addr_q[ADDR_W-1:2]
                                                                    : cq_addr_q[ADDR_W-1:2],
                                                          tag_q));
                    dval_d     = sq_pend_q ? sq_val_q : cq_val_q;
                    tkeep_d    = KEEP_WIDTH'(4'hF);
                    tlast_d    = 1'b0;
                    tuser_d    = '0;
                    tuser_d[3:0] = 4'hF;
                end
            end
            DBL_DESC: begin
                if (s_axis_rq_tready) begin
                    state_d       = DBL_DATA;
                    tdata_d       = '0;
                    tdata_d[31:0] = {16'h0, dval_q};
                    tkeep_d       = KEEP_WIDTH'(4'h1);
                    tlast_d       = 1'b1;
                end
            end
            DBL_DATA: begin
                if (s_axis_rq_tready) begin
                    state_d   = DBL_IDLE;
                    tag_d     = tag_q + 8'd1;
                    sq_done_d = !serve_cq_q;
                    cq_done_d = serve_cq_q;
                    tdata_d   = '0;
                    tkeep_d   = '0;
                    tlast_d   = 1'b0;
                    tuser_d   = '0;
                end
            end
            default: state_d = DBL_IDLE;
        endcase

        // A new request always wins over the clear, so a hit on the queue being launched re-arms it.
        if (write_sqtdbl) begin
            sq_pend_d = 1'b1;
            sq_addr_d = sqt_addr;
            sq_val_d  = sqt_val;
        end else if (start_sq) begin
            sq_pend_d = 1'b0;
        end

        if (write_cqhdbl) begin
            cq_pend_d = 1'b1;
            cq_addr_d = cqh_addr;
            cq_val_d  = cqh_val;
        end else if (start_cq) begin
            cq_pend_d = 1'b0;
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q    <= DBL_IDLE;
            sq_pend_q  <= 1'b0;
            cq_pend_q  <= 1'b0;
            sq_addr_q  <= '0;
            cq_addr_q  <= '0;
            sq_val_q   <= '0;
            cq_val_q   <= '0;
            dval_q     <= '0;
            serve_cq_q <= 1'b0;
            tag_q      <= '0;
            sq_done_q  <= 1'b0;
            cq_done_q  <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tuser_q    <= '0;
        end else begin
            state_q    <= state_d;
            sq_pend_q  <= sq_pend_d;
            cq_pend_q  <= cq_pend_d;
            sq_addr_q  <= sq_addr_d;
            cq_addr_q  <= cq_addr_d;
            sq_val_q   <= sq_val_d;
            cq_val_q   <= cq_val_d;
            dval_q     <= dval_d;
            serve_cq_q <= serve_cq_d;
            tag_q      <= tag_d;
            sq_done_q  <= sq_done_d;
            cq_done_q  <= cq_done_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
        end
    end

    assign s_axis_rq_tvalid  = (state_q != DBL_IDLE);
    assign s_axis_rq_tdata   = tdata_q;
    assign s_axis_rq_tkeep   = tkeep_q;
    assign s_axis_rq_tlast   = tlast_q;
    assign s_axis_rq_tuser   = tuser_q;
    assign write_sqtdbl_done = sq_done_q;
    assign write_cqhdbl_done = cq_done_q;
    assign dbl_busy          = sq_pend_q || cq_pend_q || (state_q != DBL_IDLE);

endmodule

// File: tb/tb_doorbell_writer.sv
// Scoreboard bench for doorbell_writer: expected beats and done pulses queued at stimulus time.
module tb_doorbell_writer;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         write_sqtdbl = 1'b0;
    logic [63:0]  sqt_addr = '0;
    logic [15:0]  sqt_val = '0;
    logic         write_cqhdbl = 1'b0;
    logic [63:0]  cqh_addr = '0;
    logic [15:0]  cqh_val = '0;
    logic         sq_done, cq_done;
    logic [127:0] tdata;
    logic [3:0]   tkeep;
    logic         tlast;
    logic [61:0]  tuser;
    logic         tvalid;
    logic         tready = 1'b1;
    logic         busy;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t beat_q[$];
    int    done_q[$];
    logic [7:0] exp_tag = 8'd0;

    doorbell_writer #(
        .C_DATA_WIDTH       (128),
        .AXI4_RQ_TUSER_WIDTH(62),
        .KEEP_WIDTH         (4)
    ) dut (
        .user_clk         (clk),
        .user_reset_n     (rst_n),
        .write_sqtdbl     (write_sqtdbl),
        .sqt_addr         (sqt_addr),
        .sqt_val          (sqt_val),
        .write_cqhdbl     (write_cqhdbl),
        .cqh_addr         (cqh_addr),
        .cqh_val          (cqh_val),
        .write_sqtdbl_done(sq_done),
        .write_cqhdbl_done(cq_done),
        .s_axis_rq_tdata  (tdata),
        .s_axis_rq_tkeep  (tkeep),
        .s_axis_rq_tlast  (tlast),
        .s_axis_rq_tuser  (tuser),
        .s_axis_rq_tvalid (tvalid),
        .s_axis_rq_tready (tready),
        .dbl_busy         (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish before 500us");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Expected TLP built field by field from the doorbell's bus address, value and tag.
    task automatic expect_tlp(input logic [63:0] addr, input logic [15:0] val, input int q);
        beat_t b;
        b.data          = '0;
        b.data[63:2]    = addr[63:2];
        b.data[74:64]   = 11'd1;
        b.data[78:75]   = 4'b0001;
        b.data[103:96]  = exp_tag;
        b.keep          = 4'hF;
        b.last          = 1'b0;
        beat_q.push_back(b);
        b.data          = '0;
        b.data[15:0]    = val;
        b.keep          = 4'h1;
        b.last          = 1'b1;
        beat_q.push_back(b);
        done_q.push_back(q);
        exp_tag = exp_tag + 8'd1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata %h, required no beat", tdata);
                end else begin
                    check("beat_tdata", tdata, beat_q[0].data);
                    check("beat_tkeep", 128'(tkeep), 128'(beat_q[0].keep));
                    check("beat_tlast", 128'(tlast), 128'(beat_q[0].last));
                    check("beat_tuser", 128'(tuser), 128'h0F);
                    if (tready) void'(beat_q.pop_front());
                end
            end
            if (sq_done || cq_done) begin
                n_checks++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_pulse: got sq=%0b cq=%0b, required none", sq_done, cq_done);
                end else begin
                    if ((sq_done && cq_done) || (sq_done != (done_q[0] == 0))) begin
                        n_fail++;
                        $display("FAIL done_order: got sq=%0b cq=%0b, required queue %0d",
                                 sq_done, cq_done, done_q[0]);
                    end
                    void'(done_q.pop_front());
                end
            end
        end
    end

    task automatic pulse(input logic sq, input logic [63:0] sa, input logic [15:0] sv,
                         input logic cq, input logic [63:0] ca, input logic [15:0] cv);
        write_sqtdbl = sq; sqt_addr = sa; sqt_val = sv;
        write_cqhdbl = cq; cqh_addr = ca; cqh_val = cv;
        @(posedge clk); #1;
        write_sqtdbl = 1'b0;
        write_cqhdbl = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_valid_wait"}, 128'(tvalid), 128'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || tvalid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_idle_wait"}, 128'(busy), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_beats_left"}, 128'(beat_q.size()), 128'd0);
        check({name, "_dones_left"}, 128'(done_q.size()), 128'd0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_tag = 8'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_tvalid", 128'(tvalid), 128'd0);
        check("rst_busy",   128'(busy), 128'd0);
        check("rst_tdata",  tdata, 128'd0);
        check("rst_tkeep_tuser_tlast", 128'({tkeep, tuser, tlast}), 128'd0);
        check("rst_done",   128'({sq_done, cq_done}), 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single SQ, plus launch latency
        expect_tlp(64'h1000, 16'd5, 0);
        pulse(1'b1, 64'h1000, 16'd5, 1'b0, '0, '0);
        check("lat_edgeN_tvalid", 128'(tvalid), 128'd0);
        check("lat_edgeN_busy",   128'(busy), 128'd1);
        @(posedge clk); #1;
        check("lat_edgeN1_tvalid", 128'(tvalid), 128'd1);
        wait_idle("single");
        do_reset();

        // simultaneous: SQ first
        expect_tlp(64'h1000, 16'd11, 0);
        expect_tlp(64'h2000, 16'd22, 1);
        pulse(1'b1, 64'h1000, 16'd11, 1'b1, 64'h2000, 16'd22);
        wait_idle("simul");
        do_reset();

        // backpressure in DESC then DATA
        tready = 1'b0;
        expect_tlp(64'hDEAD_BEEF_0000_1234, 16'hABCD, 0);
        pulse(1'b1, 64'hDEAD_BEEF_0000_1237, 16'hABCD, 1'b0, '0, '0);
        wait_valid("bp");
        repeat (5) @(posedge clk);
        #1 tready = 1'b1;
        @(posedge clk); #1 tready = 1'b0;
        check("bp_in_data_tlast", 128'(tlast), 128'd1);
        repeat (5) @(posedge clk);
        #1 tready = 1'b1;
        wait_idle("bp");
        do_reset();

        // coalescing of CQ requests while SQ is in flight
        expect_tlp(64'h3000, 16'd9, 0);
        expect_tlp(64'h2000, 16'd7, 1);
        pulse(1'b1, 64'h3000, 16'd9, 1'b0, '0, '0);
        wait_valid("coal");
        pulse(1'b0, '0, '0, 1'b1, 64'h2000, 16'd3);
        pulse(1'b0, '0, '0, 1'b1, 64'h2000, 16'd7);
        wait_idle("coal");
        do_reset();

        // reset while stalled in DATA
        tready = 1'b0;
        expect_tlp(64'h4000, 16'd1, 0);
        pulse(1'b1, 64'h4000, 16'd1, 1'b0, '0, '0);
        wait_valid("rstmid");
        #1 tready = 1'b1;
        @(posedge clk); #1 tready = 1'b0;
        @(posedge clk); #1;
        check("rstmid_pre_tlast", 128'(tlast), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_tvalid", 128'(tvalid), 128'd0);
        check("rstmid_busy",   128'(busy), 128'd0);
        check("rstmid_done",   128'({sq_done, cq_done}), 128'd0);
        check("rstmid_beats_left", 128'(beat_q.size()), 128'd1);
        beat_q.delete();
        done_q.delete();
        exp_tag = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_stays_idle", 128'({tvalid, busy}), 128'd0);

        // tag wrap over 257 TLPs
        for (int i = 0; i < 257; i++) begin
            expect_tlp(64'h5000 + 64'(i * 4), 16'(i), 0);
            pulse(1'b1, 64'h5000 + 64'(i * 4), 16'(i), 1'b0, '0, '0);
            wait_idle("wrap");
        end
        check("wrap_model_tag", 128'(exp_tag), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
